// File: rtl/icmem_pkg.sv
// Shared defaults and encodings for the instruction prefetch buffer.
package icmem_pkg;
  localparam int PCW_DEF    = 16;
  localparam int ISAW_DEF   = 16;
  localparam int FETCHW_DEF = 2;
  localparam int DEPTH_DEF  = 8;

  // Pointer / occupancy widths for the default depth; count needs one extra
  // bit so a completely full buffer (DEPTH words) is representable.
  localparam int PTRW = $clog2(DEPTH_DEF);
  localparam int CNTW = PTRW + 1;

  // Words consumed by decode in one cycle.
  typedef enum logic [1:0] {
    POP0 = 2'd0,
    POP1 = 2'd1,
    POP2 = 2'd2
  } pop_e;
endpackage

// File: rtl/icmem_ring.sv
// DEPTH x ISAW circular word store: FETCHW-wide write port, head and
// head+1 read taps, pointer advance and flush.
module icmem_ring
  import icmem_pkg::*;
#(
  parameter int ISAW   = ISAW_DEF,
  parameter int FETCHW = FETCHW_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                     Clk_i,
  input  logic                     Rst_i,
  input  logic                     flush_i,
  input  logic                     we_i,
  input  logic [FETCHW*ISAW-1:0]   wdata_i,
  input  logic [1:0]               pop_i,
  output logic [ISAW-1:0]          rd_curr_o,
  output logic [ISAW-1:0]          rd_next_o
);
  localparam int RPW = $clog2(DEPTH);

  logic [DEPTH-1:0][ISAW-1:0]  mem;
  logic [RPW-1:0]              rptr, wptr, rnext;
  logic [FETCHW-1:0][RPW-1:0]  widx;

  // Per-lane write slot; truncation to RPW bits gives the modulo-DEPTH wrap.
  for (genvar k = 0; k < FETCHW; k++) begin : g_lane
    assign widx[k] = wptr + RPW'(k);
  end

  assign rnext     = rptr + RPW'(1);
  assign rd_curr_o = mem[rptr];
  assign rd_next_o = mem[rnext];

  // Storage write and pointer update; flush only rewinds pointers since
  // the stale contents become unreachable once count is zero.
  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      mem  <= '0;
      rptr <= '0;
      wptr <= '0;
    end else if (flush_i) begin
      rptr <= '0;
      wptr <= '0;
    end else begin
      if (we_i) begin
        for (int k = 0; k < FETCHW; k++)
          mem[widx[k]] <= wdata_i[k*ISAW +: ISAW];
        wptr <= wptr + RPW'(FETCHW);
      end
      rptr <= rptr + RPW'(pop_i);
    end
  end
endmodule

// File: rtl/icmem_fetch_buf.sv
// Instruction prefetch buffer: fetches FETCHW words per cycle from an
// external combinational ROM and feeds 1 or 2 words per cycle to decode.
module icmem_fetch_buf
  import icmem_pkg::*;
#(
  parameter int             PCW      = PCW_DEF,
  parameter int             ISAW     = ISAW_DEF,
  parameter int             FETCHW   = FETCHW_DEF,
  parameter int             DEPTH    = DEPTH_DEF,
  parameter logic [PCW-1:0] RESET_PC = '0
) (
  input  logic                     Clk_i,
  input  logic                     Rst_i,
  input  logic                     Redir_i,
  input  logic [PCW-1:0]           RedirPc_i,
  output logic [PCW-1:0]           RomAddr_o,
  output logic                     RomRe_o,
  input  logic [FETCHW*ISAW-1:0]   RomData_i,
  input  logic                     Ready_i,
  input  logic                     ML_en_i,
  output logic [ISAW-1:0]          InsCurr_o,
  output logic [ISAW-1:0]          InsNext_o,
  output logic                     Valid_o,
  output logic                     ValidPair_o,
  output logic [PCW-1:0]           CurrPc_o,
  output logic [$clog2(DEPTH):0]   Count_o
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [PCW-1:0] fetch_pc;
  logic [CW-1:0]  cnt;
  logic           rom_re;
  pop_e           pop;

  // Fetch admission and decode consumption. Space is judged on the
  // pre-pop count; a long instruction is never partially consumed.
  always_comb begin
    rom_re = !Rst_i && !Redir_i && (cnt <= CW'(DEPTH - FETCHW));
    pop    = POP0;
    if (!Redir_i && Ready_i) begin
      if (ML_en_i) begin
        if (cnt >= CW'(2)) pop = POP2;
      end else if (cnt >= CW'(1)) begin
        pop = POP1;
      end
    end
  end

  // Fetch PC and occupancy; reset beats redirect, redirect beats push/pop.
  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      fetch_pc <= RESET_PC;
      cnt      <= '0;
    end else if (Redir_i) begin
      fetch_pc <= RedirPc_i;
      cnt      <= '0;
    end else begin
      if (rom_re) fetch_pc <= fetch_pc + PCW'(FETCHW);
      cnt <= cnt + (rom_re ? CW'(FETCHW) : '0) - CW'(pop);
    end
  end

  icmem_ring #(
    .ISAW   (ISAW),
    .FETCHW (FETCHW),
    .DEPTH  (DEPTH)
  ) u_ring (
    .Clk_i     (Clk_i),
    .Rst_i     (Rst_i),
    .flush_i   (Redir_i),
    .we_i      (rom_re),
    .wdata_i   (RomData_i),
    .pop_i     (pop),
    .rd_curr_o (InsCurr_o),
    .rd_next_o (InsNext_o)
  );

  assign RomAddr_o   = fetch_pc;
  assign RomRe_o     = rom_re;
  assign Valid_o     = (cnt != '0);
  assign ValidPair_o = (cnt >= CW'(2));
  // Head PC is the fetch PC rewound by the words still buffered.
  assign CurrPc_o    = fetch_pc - PCW'(cnt);
  assign Count_o     = cnt;
endmodule

// File: tb/tb_icmem_fetch_buf.sv
// Scoreboard bench for icmem_fetch_buf: fetched words are queued with
// their PCs as the model predicts a fetch, and popped as decode consumes.
module tb_icmem_fetch_buf;
  localparam int PCW = 16, ISAW = 16, FETCHW = 2, DEPTH = 8;
  localparam logic [15:0] RST_PC = 16'h0000;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] word;
  } ent_t;

  logic                   Clk = 1'b0;
  logic                   Rst, Redir, Ready, ML;
  logic [15:0]            RedirPc, RomAddr, InsCurr, InsNext, CurrPc;
  logic                   RomRe, Valid, ValidPair;
  logic [3:0]             Count;
  logic [FETCHW*ISAW-1:0] RomData;

  ent_t        sb[$];
  logic [15:0] m_fpc;
  int          vectors = 0, miscompares = 0;

  always #5 Clk = ~Clk;

  icmem_fetch_buf #(
    .PCW(PCW), .ISAW(ISAW), .FETCHW(FETCHW), .DEPTH(DEPTH), .RESET_PC(RST_PC)
  ) dut (
    .Clk_i(Clk), .Rst_i(Rst), .Redir_i(Redir), .RedirPc_i(RedirPc),
    .RomAddr_o(RomAddr), .RomRe_o(RomRe), .RomData_i(RomData),
    .Ready_i(Ready), .ML_en_i(ML), .InsCurr_o(InsCurr), .InsNext_o(InsNext),
    .Valid_o(Valid), .ValidPair_o(ValidPair), .CurrPc_o(CurrPc), .Count_o(Count)
  );

  // Scrambled ROM contents so a word can never be mistaken for its address.
  function automatic logic [15:0] rom(input logic [15:0] a);
    return a ^ 16'hA5C3;
  endfunction

  always_comb
    for (int k = 0; k < FETCHW; k++)
      RomData[k*ISAW +: ISAW] = rom(RomAddr + 16'(k));

  // Expected {RomRe, Valid, ValidPair, Count} from the scoreboard occupancy.
  function automatic logic [6:0] e_stat();
    int n;
    n = sb.size();
    return {(!Rst && !Redir && n <= DEPTH - FETCHW), (n >= 1), (n >= 2), 4'(n)};
  endfunction

  function automatic logic [15:0] e_pc();
    return (sb.size() > 0) ? sb[0].pc : m_fpc;
  endfunction

  // Advance the reference model with the inputs currently applied, then
  // clock the DUT and land 1 time unit after the edge.
  task automatic adv();
    int   n;
    int   pop;
    logic re;
    n = sb.size();
    pop = 0;
    if (Rst) begin
      sb.delete(); m_fpc = RST_PC;
    end else if (Redir) begin
      sb.delete(); m_fpc = RedirPc;
    end else begin
      re = (n <= DEPTH - FETCHW);
      if (Ready && ML && n >= 2) pop = 2;
      else if (Ready && !ML && n >= 1) pop = 1;
      repeat (pop) void'(sb.pop_front());
      if (re) begin
        for (int k = 0; k < FETCHW; k++)
          sb.push_back('{pc: m_fpc + 16'(k), word: rom(m_fpc + 16'(k))});
        m_fpc = m_fpc + 16'(FETCHW);
      end
    end
    @(posedge Clk); #1;
  endtask

  task automatic test_reset();
    Rst = 1; Redir = 1; RedirPc = 16'h1234; Ready = 1; ML = 0;
    adv(); adv();
    vectors++; if ({RomRe, Valid, ValidPair, Count} !== 7'b000_0000) begin
      miscompares++; $display("FAIL reset.stat got=%b exp=%b", {RomRe, Valid, ValidPair, Count}, 7'b0); end
    vectors++; if (RomAddr !== RST_PC) begin
      miscompares++; $display("FAIL reset.romaddr got=%h exp=%h", RomAddr, RST_PC); end
    vectors++; if (CurrPc !== RST_PC) begin
      miscompares++; $display("FAIL reset.currpc got=%h exp=%h", CurrPc, RST_PC); end
    vectors++; if ({InsCurr, InsNext} !== 32'h0) begin
      miscompares++; $display("FAIL reset.ins got=%h exp=0", {InsCurr, InsNext}); end
  endtask

  // Free-running stream: short instructions first, then alternating long/short.
  task automatic test_stream();
    Rst = 0; Redir = 0; Ready = 1; ML = 0;
    for (int i = 0; i < 20; i++) begin
      ML = (i >= 10) ? i[0] : 1'b0;
      #1;
      vectors++; if ({RomRe, Valid, ValidPair, Count} !== e_stat()) begin
        miscompares++; $display("FAIL stream.stat cyc=%0d got=%b exp=%b", i, {RomRe, Valid, ValidPair, Count}, e_stat()); end
      vectors++; if (RomAddr !== m_fpc) begin
        miscompares++; $display("FAIL stream.romaddr cyc=%0d got=%h exp=%h", i, RomAddr, m_fpc); end
      vectors++; if (CurrPc !== e_pc()) begin
        miscompares++; $display("FAIL stream.currpc cyc=%0d got=%h exp=%h", i, CurrPc, e_pc()); end
      if (sb.size() >= 1) begin
        vectors++; if (InsCurr !== sb[0].word) begin
          miscompares++; $display("FAIL stream.inscurr cyc=%0d got=%h exp=%h", i, InsCurr, sb[0].word); end
      end
      adv();
    end
  endtask

  // Fill to DEPTH with decode stalled, then drain in pairs with refill.
  task automatic test_fill();
    Rst = 1; Redir = 0; Ready = 0; ML = 0;
    adv();
    Rst = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      vectors++; if ({RomRe, Valid, ValidPair, Count} !== e_stat()) begin
        miscompares++; $display("FAIL fill.stat cyc=%0d got=%b exp=%b", i, {RomRe, Valid, ValidPair, Count}, e_stat()); end
      vectors++; if (RomAddr !== m_fpc) begin
        miscompares++; $display("FAIL fill.romaddr cyc=%0d got=%h exp=%h", i, RomAddr, m_fpc); end
      adv();
    end
    vectors++; if (Count !== 4'd8 || RomRe !== 1'b0 || RomAddr !== 16'h0008) begin
      miscompares++; $display("FAIL fill.full got cnt=%0d re=%b addr=%h exp cnt=8 re=0 addr=0008", Count, RomRe, RomAddr); end
    Ready = 1; ML = 1;
    for (int i = 0; i < 8; i++) begin
      #1;
      vectors++; if ({RomRe, Valid, ValidPair, Count} !== e_stat()) begin
        miscompares++; $display("FAIL drain.stat cyc=%0d got=%b exp=%b", i, {RomRe, Valid, ValidPair, Count}, e_stat()); end
      if (sb.size() >= 2) begin
        vectors++; if ({InsCurr, InsNext} !== {sb[0].word, sb[1].word}) begin
          miscompares++; $display("FAIL drain.pair cyc=%0d got=%h exp=%h", i, {InsCurr, InsNext}, {sb[0].word, sb[1].word}); end
      end
      adv();
    end
  endtask

  // Long-instruction request on an empty buffer must not pop or underflow.
  task automatic test_pair_guard();
    Redir = 1; RedirPc = 16'h0040; Ready = 1; ML = 1;
    adv();
    Redir = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      vectors++; if ({RomRe, Valid, ValidPair, Count} !== e_stat()) begin
        miscompares++; $display("FAIL guard.stat cyc=%0d got=%b exp=%b", i, {RomRe, Valid, ValidPair, Count}, e_stat()); end
      vectors++; if (CurrPc !== e_pc()) begin
        miscompares++; $display("FAIL guard.currpc cyc=%0d got=%h exp=%h", i, CurrPc, e_pc()); end
      adv();
    end
  endtask

  // Redirect while partially full; then 2-edge latency to the new head.
  task automatic test_redirect();
    bit hit;
    hit = 0;
    Redir = 0; Ready = 1; ML = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (sb.size() == 6) hit = 1;
      else adv();
    end
    vectors++; if (!hit || Count !== 4'd6) begin
      miscompares++; $display("FAIL redir.setup got cnt=%0d reached=%0d exp cnt=6", Count, hit); end
    Redir = 1; RedirPc = 16'h0100;
    #1;
    vectors++; if (RomRe !== 1'b0) begin
      miscompares++; $display("FAIL redir.romre got=%b exp=0", RomRe); end
    adv();
    Redir = 0;
    #1;
    vectors++; if ({RomRe, Valid, Count, RomAddr} !== {1'b1, 1'b0, 4'd0, 16'h0100}) begin
      miscompares++; $display("FAIL redir.edge1 got re=%b v=%b cnt=%0d addr=%h exp re=1 v=0 cnt=0 addr=0100", RomRe, Valid, Count, RomAddr); end
    adv();
    vectors++; if ({Valid, InsCurr, CurrPc} !== {1'b1, rom(16'h0100), 16'h0100}) begin
      miscompares++; $display("FAIL redir.edge2 got v=%b ins=%h pc=%h exp v=1 ins=%h pc=0100", Valid, InsCurr, CurrPc, rom(16'h0100)); end
  endtask

  // PC wrap at the top of the address space.
  task automatic test_wrap();
    Redir = 1; RedirPc = 16'hFFFE; Ready = 1; ML = 1;
    adv();
    Redir = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      vectors++; if (RomAddr !== m_fpc || CurrPc !== e_pc()) begin
        miscompares++; $display("FAIL wrap.pc cyc=%0d got addr=%h pc=%h exp addr=%h pc=%h", i, RomAddr, CurrPc, m_fpc, e_pc()); end
      if (sb.size() >= 2) begin
        vectors++; if ({InsCurr, InsNext} !== {sb[0].word, sb[1].word}) begin
          miscompares++; $display("FAIL wrap.pair cyc=%0d got=%h exp=%h", i, {InsCurr, InsNext}, {sb[0].word, sb[1].word}); end
      end
      adv();
    end
  endtask

  // Two redirects in a row: only the last target survives.
  task automatic test_back_to_back();
    Redir = 1; RedirPc = 16'h0200; Ready = 1; ML = 0;
    adv();
    RedirPc = 16'h0300;
    adv();
    Redir = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      vectors++; if ({RomRe, Valid, ValidPair, Count} !== e_stat()) begin
        miscompares++; $display("FAIL b2b.stat cyc=%0d got=%b exp=%b", i, {RomRe, Valid, ValidPair, Count}, e_stat()); end
      if (sb.size() >= 1) begin
        vectors++; if ({InsCurr, CurrPc} !== {sb[0].word, sb[0].pc}) begin
          miscompares++; $display("FAIL b2b.head cyc=%0d got=%h exp=%h", i, {InsCurr, CurrPc}, {sb[0].word, sb[0].pc}); end
      end
      adv();
    end
  endtask

  // Reset asserted together with a redirect mid-stream.
  task automatic test_reset_mid();
    Rst = 0; Redir = 0; Ready = 1; ML = 0;
    adv(); adv(); adv();
    Rst = 1; Redir = 1; RedirPc = 16'h0500;
    adv();
    vectors++; if ({RomRe, Valid, ValidPair, Count} !== 7'b000_0000) begin
      miscompares++; $display("FAIL rstmid.stat got=%b exp=%b", {RomRe, Valid, ValidPair, Count}, 7'b0); end
    vectors++; if ({RomAddr, CurrPc} !== {RST_PC, RST_PC}) begin
      miscompares++; $display("FAIL rstmid.pc got addr=%h pc=%h exp=%h", RomAddr, CurrPc, RST_PC); end
    vectors++; if ({InsCurr, InsNext} !== 32'h0) begin
      miscompares++; $display("FAIL rstmid.ins got=%h exp=0", {InsCurr, InsNext}); end
    Rst = 0; Redir = 0;
  endtask

  initial begin
    Rst = 1; Redir = 0; RedirPc = '0; Ready = 0; ML = 0;
    test_reset();
    test_stream();
    test_fill();
    test_pair_guard();
    test_redirect();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
